// File: rtl/integrate_dump_pkg.sv
// integrate_dump_pkg: counter sizing and saturation bounds shared by integrate_dump and its adder
package integrate_dump_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/integrate_dump_if.sv
// integrate_dump_if: valid/ready data stream; master drives data/valid, slave drives ready
interface integrate_dump_if #(parameter int W = 17) ();
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/integrate_dump_sat_add.sv
// integrate_dump_sat_add: combinational signed adder, optionally clamping to the signed W-bit range
module integrate_dump_sat_add
  import integrate_dump_pkg::*;
#(
  parameter int W = 24,
  parameter bit SAT_EN = 1'b0
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                ovf
);
  localparam logic signed [W-1:0] smax = W'(sat_max(W));
  localparam logic signed [W-1:0] smin = W'(sat_min(W));
  logic signed [W-1:0] sum;
  logic wrap;
  always_comb begin
    sum = a + b;
    wrap = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    ovf = SAT_EN && wrap;
    y = ovf ? (a[W-1] ? smin : smax) : sum;
  end
endmodule

// File: rtl/integrate_dump.sv
// integrate_dump: sums DUMP_LEN accepted samples, emits the total on a valid/ready stream and restarts.
// Define INTEGRATE_DUMP_SAT_EN for saturating adds and a sticky ovf_o; otherwise adds wrap and ovf_o is 0.
module integrate_dump
  import integrate_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int ACC_WIDTH = 24,
  parameter int DUMP_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  integrate_dump_if.slave  s_in,
  integrate_dump_if.master m_out,
  output logic ovf_o
);
`ifdef INTEGRATE_DUMP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int CW = clog2(DUMP_LEN);
  logic [CW-1:0] cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt, data_q, x;
  logic valid_q, ovf_q, add_ovf, last, accept;
  assign last = cnt == CW'(DUMP_LEN - 1);
  // stall only when the completing sample would overwrite an unconsumed total
  assign s_in.ready = !(valid_q && !m_out.ready && last);
  assign accept = s_in.valid && s_in.ready;
  assign x = ACC_WIDTH'($signed(s_in.data[DATA_WIDTH-1:0]));
  assign m_out.data = data_q;
  assign m_out.valid = valid_q;
  assign ovf_o = ovf_q;
  integrate_dump_sat_add #(.W(ACC_WIDTH), .SAT_EN(SAT_EN)) u_add (
    .a(acc), .b(x), .y(acc_nxt), .ovf(add_ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (m_out.ready) valid_q <= 1'b0;
      if (clear_i) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        ovf_q <= ovf_q | add_ovf;
        if (last) begin
          data_q <= acc_nxt;
          valid_q <= 1'b1;
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
